// File: rtl/dcmotor_pwm_ctrl.sv
// ----------------------------------------------------------------------------
// dcmotor_pwm_ctrl
//
// Single-motor H-bridge PWM controller. A 4-row active-low keypad selects a
// target duty, which is debounced and then applied through a duty ramp. A
// direction change is handled as decelerate -> dead-time -> re-accelerate, so
// the two bridge halves are never driven together.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   dir       requested direction, 1 = forward (mtr1), 0 = reverse (mtr2);
//             asynchronous, synchronised internally
//   row[3:0]  keypad rows, active-low, asynchronous, synchronised internally
//   en        bridge enable (high in RUN_FWD / RUN_REV / DECEL)
//   mtr1      forward PWM drive
//   mtr2      reverse PWM drive
//   duty_cur  currently applied duty
//   state_o   FSM state: 0 STOP, 1 RUN_FWD, 2 RUN_REV, 3 DECEL, 4 DEAD
//
// Build option:
//   SOFT_RAMP_EN  defined   : duty_cur moves 1 LSB toward the effective target
//                             every RAMP_TICKS PWM steps.
//                 undefined : duty_cur loads the effective target directly,
//                             so DECEL lasts a single clock.
// ----------------------------------------------------------------------------
module dcmotor_pwm_ctrl #(
    parameter int CNT_W        = 8,
    parameter int PRESCALE     = 256,
    parameter int DUTY_K0      = 250,
    parameter int DUTY_K1      = 190,
    parameter int DUTY_K2      = 100,
    parameter int DUTY_K3      = 0,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int RAMP_TICKS   = 4,
    parameter int DEAD_CYC     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir,
    input  logic [3:0]       row,
    output logic             en,
    output logic             mtr1,
    output logic             mtr2,
    output logic [CNT_W-1:0] duty_cur,
    output logic [2:0]       state_o
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DB_W   = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(PRESCALE - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);

    localparam logic [CNT_W-1:0] K0 = CNT_W'(DUTY_K0);
    localparam logic [CNT_W-1:0] K1 = CNT_W'(DUTY_K1);
    localparam logic [CNT_W-1:0] K2 = CNT_W'(DUTY_K2);
    localparam logic [CNT_W-1:0] K3 = CNT_W'(DUTY_K3);

    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_RUN_FWD = 3'd1,
        ST_RUN_REV = 3'd2,
        ST_DECEL   = 3'd3,
        ST_DEAD    = 3'd4
    } state_t;

    // A keypad code is usable only when exactly one row is pulled low.
    function automatic logic one_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [CNT_W-1:0] key_duty(input logic [3:0] r);
        logic [CNT_W-1:0] d;
        case (r)
            4'b1110: d = K0;
            4'b1101: d = K1;
            4'b1011: d = K2;
            4'b0111: d = K3;
            default: d = '0;
        endcase
        return d;
    endfunction

    state_t            state;
    state_t            state_next;
    logic              dir_meta;
    logic              dir_s;
    logic [3:0]        row_meta;
    logic [3:0]        row_s;
    logic [PRE_W-1:0]  pre_cnt;
    logic              step;
    logic [CNT_W-1:0]  pwm_cnt;
    logic [3:0]        row_q;
    logic [DB_W-1:0]   db_cnt;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  eff_target;
    logic [DEAD_W-1:0] dead_cnt;
    logic              dead_done;
    logic              from_fwd;
    logic              pwm_on;
    logic              en_p0;
    logic              mtr1_p0;
    logic              mtr2_p0;

    // ---- Input synchronisers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_meta <= 1'b0;
            dir_s    <= 1'b0;
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            dir_meta <= dir;
            dir_s    <= dir_meta;
            row_meta <= row;
            row_s    <= row_meta;
        end
    end

    // ---- Prescaler and PWM counter ----
    assign step = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (step) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // ---- Keypad debounce ----
    // The counter saturates at DEBOUNCE_CYC so a held key loads target only
    // once; any release, change or multi-key code restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= 4'hF;
            db_cnt <= '0;
            target <= '0;
        end else begin
            row_q <= row_s;
            if (!one_low(row_s) || (row_s != row_q)) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + DB_W'(1);
                if (db_cnt == DB_LOAD) begin
                    target <= key_duty(row_s);
                end
            end
        end
    end

    // ---- Applied duty ----
`ifdef SOFT_RAMP_EN
    localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_TICKS - 1);

    logic [RAMP_W-1:0] ramp_cnt;

    // One-LSB move toward tgt; equal inputs hold, so no over/undershoot.
    function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        if (cur < tgt) return cur + CNT_W'(1);
        if (cur > tgt) return cur - CNT_W'(1);
        return cur;
    endfunction

    assign eff_target = (state == ST_DECEL) ? '0 : target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_cnt <= '0;
            duty_cur <= '0;
        end else if (step) begin
            if (ramp_cnt == RAMP_MAX) begin
                ramp_cnt <= '0;
                duty_cur <= step_toward(duty_cur, eff_target);
            end else begin
                ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
        end
    end
`else
    // Without the ramp, duty follows the state being entered, so duty is
    // already 0 on the first DECEL clock and DECEL exits after one clock.
    assign eff_target = (state_next == ST_DECEL) ? '0 : target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cur <= '0;
        end else begin
            duty_cur <= eff_target;
        end
    end
`endif

    // ---- FSM state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // Dead-time counter and the direction being left when entering DECEL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_cnt <= '0;
            from_fwd <= 1'b0;
        end else begin
            if ((state == ST_DECEL) && (state_next == ST_DEAD)) begin
                dead_cnt <= DEAD_LOAD;
            end else if ((state == ST_DEAD) && (dead_cnt != '0)) begin
                dead_cnt <= dead_cnt - DEAD_W'(1);
            end
            if ((state == ST_RUN_FWD) && (state_next == ST_DECEL)) begin
                from_fwd <= 1'b1;
            end else if ((state == ST_RUN_REV) && (state_next == ST_DECEL)) begin
                from_fwd <= 1'b0;
            end
        end
    end

    // Leave DEAD as the counter reaches 0, giving exactly DEAD_CYC clocks.
    assign dead_done = (dead_cnt <= DEAD_W'(1));

    // ---- FSM next state ----
    always_comb begin
        state_next = state;
        case (state)
            ST_STOP: begin
                if (target != '0) begin
                    state_next = dir_s ? ST_RUN_FWD : ST_RUN_REV;
                end
            end
            ST_RUN_FWD: begin
                if (!dir_s) begin
                    state_next = ST_DECEL;
                end else if ((target == '0) && (duty_cur == '0)) begin
                    state_next = ST_STOP;
                end
            end
            ST_RUN_REV: begin
                if (dir_s) begin
                    state_next = ST_DECEL;
                end else if ((target == '0) && (duty_cur == '0)) begin
                    state_next = ST_STOP;
                end
            end
            ST_DECEL: begin
                if (duty_cur == '0) begin
                    state_next = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (dead_done) begin
                    if (target != '0) begin
                        state_next = dir_s ? ST_RUN_FWD : ST_RUN_REV;
                    end else begin
                        state_next = ST_STOP;
                    end
                end
            end
            default: state_next = ST_STOP;
        endcase
    end

    // ---- FSM outputs (compare stage) ----
    assign pwm_on = (pwm_cnt < duty_cur);

    always_comb begin
        en_p0   = 1'b0;
        mtr1_p0 = 1'b0;
        mtr2_p0 = 1'b0;
        case (state)
            ST_RUN_FWD: begin
                en_p0   = 1'b1;
                mtr1_p0 = pwm_on;
            end
            ST_RUN_REV: begin
                en_p0   = 1'b1;
                mtr2_p0 = pwm_on;
            end
            ST_DECEL: begin
                en_p0   = 1'b1;
                mtr1_p0 = pwm_on & from_fwd;
                mtr2_p0 = pwm_on & ~from_fwd;
            end
            default: ;
        endcase
    end

    // ---- Registered bridge drive ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en   <= 1'b0;
            mtr1 <= 1'b0;
            mtr2 <= 1'b0;
        end else begin
            en   <= en_p0;
            mtr1 <= mtr1_p0;
            mtr2 <= mtr2_p0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_dcmotor_pwm_ctrl.sv
module tb_dcmotor_pwm_ctrl;

    logic       clk;
    logic       rst;
    logic       dir;
    logic [3:0] row;
    logic       en;
    logic       mtr1;
    logic       mtr2;
    logic [3:0] duty_cur;
    logic [2:0] state_o;

    int checks;
    int failures;
    int overlap;
    int n;
    int decel_n;
    int decel_mtr1;
    int decel_duty0;
    int en_low;
    int pre_mtr2;
    int rev_seen;
    int extra;
    int hi1;
    int hi2;
    int en_hi;

    localparam logic [2:0] S_STOP = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_REV  = 3'd2;
    localparam logic [2:0] S_DEC  = 3'd3;

    dcmotor_pwm_ctrl #(
        .CNT_W(4), .PRESCALE(2), .DUTY_K0(12), .DUTY_K1(8), .DUTY_K2(4),
        .DUTY_K3(0), .DEBOUNCE_CYC(8), .RAMP_TICKS(1), .DEAD_CYC(5)
    ) dut (
        .clk(clk), .rst(rst), .dir(dir), .row(row), .en(en),
        .mtr1(mtr1), .mtr2(mtr2), .duty_cur(duty_cur), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mtr1 && mtr2) overlap++;
    end

`ifdef SOFT_RAMP_EN
    int jump_err;
    int prev_duty;
    always @(negedge clk) begin
        if (!rst && ((int'(duty_cur) > prev_duty + 1) || (prev_duty > int'(duty_cur) + 1)))
            jump_err++;
        prev_duty = int'(duty_cur);
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
        int k = 0;
        while (state_o !== exp && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(state_o), 32'(exp));
    endtask

    task automatic wait_duty(input logic [3:0] exp, input int budget, input string tag);
        int k = 0;
        while (duty_cur !== exp && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(duty_cur), 32'(exp));
    endtask

    // Count drive activity over one full PWM period (2 * 16 clocks).
    task automatic measure_period();
        hi1 = 0; hi2 = 0; en_hi = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mtr1) hi1++;
            if (mtr2) hi2++;
            if (en) en_hi++;
        end
    endtask

    initial begin
        checks = 0; failures = 0; overlap = 0;
        rst = 1'b1; dir = 1'b1; row = 4'b1111;

        // Test 1: reset and idle
        tick(3);
        chk("t1_en", 32'(en), 0);
        chk("t1_mtr1", 32'(mtr1), 0);
        chk("t1_mtr2", 32'(mtr2), 0);
        chk("t1_duty", 32'(duty_cur), 0);
        chk("t1_state", 32'(state_o), 32'(S_STOP));
        rst = 1'b0;
        tick(4);
        chk("t1_idle_state", 32'(state_o), 32'(S_STOP));

        // Test 2: press K0 with dir=1 -> forward at duty 12
        row = 4'b1110;
        tick(20);
        row = 4'b1111;
        chk("t2_state", 32'(state_o), 32'(S_FWD));
`ifdef SOFT_RAMP_EN
        wait_duty(4'd12, 100, "t2_duty");
`else
        chk("t2_duty", 32'(duty_cur), 12);
`endif
        tick(2);
        measure_period();
        chk("t2_mtr1_on", 32'(hi1), 24);
        chk("t2_mtr2_on", 32'(hi2), 0);
        chk("t2_en_on", 32'(en_hi), 32);

        // Test 3: bouncing K1 and a two-key code are ignored
        for (int i = 0; i < 6; i++) begin
            row = 4'b1101; tick(4);
            row = 4'b1111; tick(4);
        end
        row = 4'b0011; tick(20);
        row = 4'b1111; tick(4);
        chk("t3_duty", 32'(duty_cur), 12);
        chk("t3_state", 32'(state_o), 32'(S_FWD));

        // Test 4: reversal forward -> reverse
        dir = 1'b0;
        n = 0; decel_n = 0; decel_mtr1 = 0; decel_duty0 = -1;
        en_low = 0; pre_mtr2 = 0; rev_seen = 0; extra = 0;
        while (extra < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (state_o == S_DEC) begin
                if (decel_n == 0) decel_duty0 = int'(duty_cur);
                decel_n++;
                if (mtr1) decel_mtr1++;
            end
            if (!en) en_low++;
            if (!rev_seen && mtr2) pre_mtr2++;
            if (state_o == S_REV) rev_seen = 1;
            if (rev_seen) extra++;
        end
        chk("t4_reached_rev", 32'(rev_seen), 1);
        chk("t4_dead_en_low", 32'(en_low), 5);
        chk("t4_no_mtr2_early", 32'(pre_mtr2), 0);
`ifdef SOFT_RAMP_EN
        chk("t4_decel_long", 32'(decel_n >= 24), 1);
        chk("t4_decel_mtr1", 32'(decel_mtr1 > 0), 1);
        wait_duty(4'd12, 100, "t4_rev_duty");
`else
        chk("t4_decel_len", 32'(decel_n), 1);
        chk("t4_decel_duty", 32'(decel_duty0), 0);
        chk("t4_rev_duty", 32'(duty_cur), 12);
`endif
        tick(2);
        measure_period();
        chk("t4_mtr2_on", 32'(hi2), 24);
        chk("t4_mtr1_on", 32'(hi1), 0);

        // Test 5: K3 selects duty 0 -> back to STOP
        row = 4'b0111;
        tick(20);
        row = 4'b1111;
        wait_state(S_STOP, 200, "t5_state");
        tick(2);
        chk("t5_duty", 32'(duty_cur), 0);
        chk("t5_en", 32'(en), 0);
        chk("t5_mtr2", 32'(mtr2), 0);

        // Test 6: run reverse, flip to forward, reset during DECEL
        row = 4'b1110;
        tick(20);
        row = 4'b1111;
        chk("t6_state_rev", 32'(state_o), 32'(S_REV));
`ifdef SOFT_RAMP_EN
        wait_duty(4'd12, 100, "t6_duty");
`else
        chk("t6_duty", 32'(duty_cur), 12);
`endif
        dir = 1'b1;
        wait_state(S_DEC, 10, "t6_decel");
        #1;
        chk("t6_en_before_rst", 32'(en), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_en", 32'(en), 0);
        chk("t6_rst_mtr1", 32'(mtr1), 0);
        chk("t6_rst_mtr2", 32'(mtr2), 0);
        chk("t6_rst_state", 32'(state_o), 32'(S_STOP));
        chk("t6_rst_duty", 32'(duty_cur), 0);
        @(negedge clk);
        tick(2);
        rst = 1'b0;
        tick(6);
        chk("t6_after_state", 32'(state_o), 32'(S_STOP));
        chk("t6_after_en", 32'(en), 0);

        chk("no_overlap", 32'(overlap), 0);
`ifdef SOFT_RAMP_EN
        chk("ramp_one_lsb", 32'(jump_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
